// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of NREQ requesters, holds the grant until done,
// request drop or optional hold timeout, then inserts one dead cycle.
module rr_arbiter #(
    parameter int NUMW    = 2,
    parameter int NREQ    = 2**NUMW,
    parameter int CNTW    = 8,
    parameter int MAXHOLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic            gnt_vld,
    output logic [NUMW-1:0] gnt_num,
    output logic [NREQ-1:0] gnt_map,
    output logic            tout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [NUMW-1:0] PTR_RST   = NUMW'(NREQ - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

    state_t          state_q, state_d;
    logic [NUMW-1:0] ptr_q,   ptr_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            vld_q,   vld_d;
    logic [NUMW-1:0] num_q,   num_d;
    logic [NREQ-1:0] map_q,   map_d;
    logic            tout_q,  tout_d;

    logic            pick_vld;
    logic [NUMW-1:0] pick_num;
    logic            own_req;
    logic            timeout_hit;

    function automatic logic req_at(input logic [NREQ-1:0] r, input logic [NUMW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (idx == NUMW'(i)) b = r[i];
        end
        return b;
    endfunction

    // Modulo-NREQ add so the pointer wraps correctly for non-power-of-two NREQ.
    function automatic logic [NUMW-1:0] idx_add(input logic [NUMW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return NUMW'(s % NREQ);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [NUMW-1:0] idx);
        logic [NREQ-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            m[i] = (idx == NUMW'(i));
        end
        return m;
    endfunction

    always_comb begin
        pick_vld = 1'b0;
        pick_num = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!pick_vld && req_at(req, idx_add(ptr_q, k))) begin
                pick_vld = 1'b1;
                pick_num = idx_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        own_req     = req_at(req, num_q);
        timeout_hit = (MAXHOLD != 0) && (cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        num_d   = num_q;
        map_d   = map_q;
        tout_d  = 1'b0;
        case (state_q)
            // RELEASE is the single dead cycle; it arbitrates on exit so the
            // next grant follows it directly instead of idling a second cycle.
            IDLE, RELEASE: begin
                vld_d = 1'b0;
                map_d = '0;
                if (pick_vld) begin
                    state_d = GRANT;
                    vld_d   = 1'b1;
                    num_d   = pick_num;
                    map_d   = onehot(pick_num);
                    ptr_d   = pick_num;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (done || !own_req || timeout_hit) begin
                    state_d = RELEASE;
                    vld_d   = 1'b0;
                    map_d   = '0;
                    tout_d  = timeout_hit && !done && own_req;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                map_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            num_q   <= '0;
            map_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            num_q   <= num_d;
            map_q   <= map_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt_vld = vld_q;
    assign gnt_num = num_q;
    assign gnt_map = map_q;
    assign tout    = tout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [3:0] req4 = '0;
  logic       done4 = 1'b0;
  logic       vld4, tout4;
  logic [1:0] num4;
  logic [3:0] map4;

  logic [3:0] req5 = '0;
  logic       done5 = 1'b0;
  logic       vld5, tout5;
  logic [1:0] num5;
  logic [3:0] map5;

  logic [2:0] req3 = '0;
  logic       done3 = 1'b0;
  logic       vld3, tout3;
  logic [1:0] num3;
  logic [2:0] map3;

  rr_arbiter #(.NUMW(2), .NREQ(4), .CNTW(8), .MAXHOLD(0)) u4 (
    .clk(clk), .rst(rst), .req(req4), .done(done4),
    .gnt_vld(vld4), .gnt_num(num4), .gnt_map(map4), .tout(tout4)
  );

  rr_arbiter #(.NUMW(2), .NREQ(4), .CNTW(8), .MAXHOLD(5)) u5 (
    .clk(clk), .rst(rst), .req(req5), .done(done5),
    .gnt_vld(vld5), .gnt_num(num5), .gnt_map(map5), .tout(tout5)
  );

  rr_arbiter #(.NUMW(2), .NREQ(3), .CNTW(8), .MAXHOLD(0)) u3 (
    .clk(clk), .rst(rst), .req(req3), .done(done3),
    .gnt_vld(vld3), .gnt_num(num3), .gnt_map(map3), .tout(tout3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         id;
    logic       vld;
    logic [1:0] num;
    logic [3:0] map;
    logic       tout;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   inv_errs    = 0;

  task automatic push(input int tgt, input int id, input logic v, input logic [1:0] n,
                      input logic [3:0] m, input logic t, input string nm);
    exp_t e;
    e.cyc = tgt; e.id = id; e.vld = v; e.num = n; e.map = m; e.tout = t; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t       me;
  logic       av, at;
  logic [1:0] an;
  logic [3:0] am;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      case (me.id)
        0:       begin av = vld4; an = num4; am = map4;         at = tout4; end
        1:       begin av = vld5; an = num5; am = map5;         at = tout5; end
        default: begin av = vld3; an = num3; am = {1'b0, map3}; at = tout3; end
      endcase
      vectors++;
      if (me.cyc != cyc || av !== me.vld || an !== me.num || am !== me.map || at !== me.tout) begin
        miscompares++;
        $display("FAIL %s dut%0d cyc %0d (due %0d): got vld=%b num=%0d map=%b tout=%b, expected vld=%b num=%0d map=%b tout=%b",
                 me.nm, me.id, cyc, me.cyc, av, an, am, at, me.vld, me.num, me.map, me.tout);
      end
    end
  end

  always @(negedge clk) begin
    if (map4 !== (vld4 ? (4'b0001 << num4) : 4'b0000)) begin
      inv_errs++;
      $display("FAIL invariant dut0 cyc %0d: vld=%b num=%0d map=%b", cyc, vld4, num4, map4);
    end
    if (map5 !== (vld5 ? (4'b0001 << num5) : 4'b0000)) begin
      inv_errs++;
      $display("FAIL invariant dut1 cyc %0d: vld=%b num=%0d map=%b", cyc, vld5, num5, map5);
    end
    if (map3 !== (vld3 ? 3'(3'b001 << num3) : 3'b000) || (vld3 && num3 == 2'd3)) begin
      inv_errs++;
      $display("FAIL invariant dut2 cyc %0d: vld=%b num=%0d map=%b", cyc, vld3, num3, map3);
    end
  end

  initial begin
    logic [1:0] g;
    exp_t       d;

    #1 rst = 1'b1;
    tick();
    tick();
    push(cyc, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "reset_u4");
    push(cyc, 1, 1'b0, 2'd0, 4'b0000, 1'b0, "reset_u5");
    push(cyc, 2, 1'b0, 2'd0, 4'b0000, 1'b0, "reset_u3");
    tick();
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      done4 = k[0];
      push(cyc + 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "idle");
      tick();
    end
    done4 = 1'b0;

    req4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      done4 = 1'b0;
      push(cyc + 1, 0, 1'b1, g, 4'b0001 << g, 1'b0, "rot_grant");
      tick();
      push(cyc + 1, 0, 1'b1, g, 4'b0001 << g, 1'b0, "rot_hold");
      tick();
      done4 = 1'b1;
      push(cyc + 1, 0, 1'b0, g, 4'b0000, 1'b0, "rot_dead");
      tick();
    end
    done4 = 1'b0;
    req4  = 4'b0000;
    push(cyc + 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "rot_end");
    tick();

    req4 = 4'b1010;
    push(cyc + 1, 0, 1'b1, 2'd1, 4'b0010, 1'b0, "drop_grant");
    tick();
    req4 = 4'b1000;
    push(cyc + 1, 0, 1'b0, 2'd1, 4'b0000, 1'b0, "drop_release");
    tick();
    push(cyc + 1, 0, 1'b1, 2'd3, 4'b1000, 1'b0, "drop_next");
    tick();
    req4 = 4'b0000;
    push(cyc + 1, 0, 1'b0, 2'd3, 4'b0000, 1'b0, "drop_end");
    tick();
    push(cyc + 1, 0, 1'b0, 2'd3, 4'b0000, 1'b0, "drop_idle");
    tick();

    req5 = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      push(cyc + 1, 1, 1'b1, 2'd2, 4'b0100, 1'b0, "to_hold");
      tick();
    end
    push(cyc + 1, 1, 1'b0, 2'd2, 4'b0000, 1'b1, "to_pulse");
    tick();
    for (int j = 0; j < 5; j++) begin
      push(cyc + 1, 1, 1'b1, 2'd2, 4'b0100, 1'b0, "to_regrant");
      tick();
    end
    done5 = 1'b1;
    push(cyc + 1, 1, 1'b0, 2'd2, 4'b0000, 1'b0, "to_done_same_cycle");
    tick();
    done5 = 1'b0;
    req5  = 4'b0000;
    push(cyc + 1, 1, 1'b0, 2'd2, 4'b0000, 1'b0, "to_end");
    tick();

    req3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      g = 2'(k % 3);
      done3 = 1'b0;
      push(cyc + 1, 2, 1'b1, g, 4'b0001 << g, 1'b0, "n3_grant");
      tick();
      push(cyc + 1, 2, 1'b1, g, 4'b0001 << g, 1'b0, "n3_hold");
      tick();
      done3 = 1'b1;
      push(cyc + 1, 2, 1'b0, g, 4'b0000, 1'b0, "n3_dead");
      tick();
    end
    done3 = 1'b0;
    req3  = 3'b000;
    push(cyc + 1, 2, 1'b0, 2'd0, 4'b0000, 1'b0, "n3_end");
    tick();

    req4 = 4'b0100;
    push(cyc + 1, 0, 1'b1, 2'd2, 4'b0100, 1'b0, "pre_reset_grant");
    tick();
    tick();
    rst = 1'b1;
    push(cyc, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "async_reset");
    req4 = 4'b1111;
    push(cyc + 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "reset_held");
    tick();
    rst = 1'b0;
    push(cyc + 1, 0, 1'b1, 2'd0, 4'b0001, 1'b0, "post_reset_first");
    tick();
    done4 = 1'b1;
    push(cyc + 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "post_reset_done");
    tick();
    done4 = 1'b0;
    req4  = 4'b0000;
    push(cyc + 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0, "final_idle");
    tick();

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      d = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s dut%0d: never checked, expected vld=%b num=%0d map=%b tout=%b at cyc %0d",
               d.nm, d.id, d.vld, d.num, d.map, d.tout, d.cyc);
    end

    if (vectors < 12) begin
      miscompares++;
      $display("FAIL only %0d vectors checked", vectors);
    end
    if (inv_errs != 0) begin
      miscompares = miscompares + inv_errs;
      $display("FAIL %0d grant map invariant violations", inv_errs);
    end
    if (miscompares == 0) $display("PASS");
    else                  $display("FAIL");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
